i2c_master_engine: RTL and testbench
====================================

Name: i2c_master_engine

Overview:
- Parametrised successor to the fixed-timing I2C controller control FSM. Integrates the phase counters, bit/byte counters, shift register and open-drain line drive into one block.
- Timing is set by parameters. Transfers are multi-byte, from 0 to MAX_BYTES. ACK/NACK generation in read mode is automatic.
- Sits between a register-file command interface and the I2C pads. One transaction per accepted command.

Parameters:
T_HD, 225, START hold time in clk cycles
T_LOW, 250, SCL low-phase length in clk cycles
T_HIGH, 225, SCL high-phase length in clk cycles
DRV_PT, 150, low-phase count at which SDA is updated (must be < T_LOW)
SMP_PT, 50, high-phase count at which SDA is sampled (must be < T_HIGH)
CNT_W, 10, phase counter width (must hold max(T_HD,T_LOW,T_HIGH))
MAX_BYTES, 4, maximum data bytes per transaction
LEN_W, $clog2(MAX_BYTES+1), width of cmd_len

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  high in IDLE only; command accepted when cmd_valid&&cmd_ready
cmd_addr  in  7  target address
cmd_rw  in  1  1=read, 0=write
cmd_len  in  LEN_W  data byte count
wr_data  in  8  write byte, latched in the cycle wr_req is high
wr_req  out  1  1-cycle pulse requesting the next write byte
rd_data  out  8  last received byte; holds until the next rd_valid
rd_valid  out  1  1-cycle pulse, rd_data valid
done  out  1  1-cycle pulse on return to IDLE
nack_err  out  1  sticky; set on unexpected NACK, cleared on next command accept
busy  out  1  high outside IDLE
scl_o  out  1  1=release SCL, 0=drive low
sda_o  out  1  1=release SDA, 0=drive low
sda_i  in  1  SDA pad input
scl_i  in  1  SCL pad input (used only with the optional feature)

Behaviour:
- Reset values:
  - State: IDLE.
  - cmd_ready=1, scl_o=1, sda_o=1.
  - wr_req=0, rd_valid=0, done=0, nack_err=0, busy=0, rd_data=0.
  - All counters 0.
- Reset mid-transfer releases both lines on the next clk edge. No STOP is generated.
- States and transitions. The phase counter increments every cycle in timed states and clears on every state change.
  - IDLE
    - Accept: latch addr/rw; len=min(cmd_len,MAX_BYTES); clear nack_err.
    - Load shift register with {addr,rw}.
    - Go to START with sda_o=0, scl_o=1.
  - START: when count>=T_HD-1, go to ADDR_LOW.
  - ADDR_LOW / DATA_LOW
    - scl_o=0.
    - At count==DRV_PT: sda_o=shift MSB in write/address phases; sda_o=1 in read.
    - At count==T_LOW-1, go to the matching HIGH state.
  - ADDR_HIGH / DATA_HIGH
    - scl_o=1.
    - At count==SMP_PT: shift in sda_i (read data) and increment bit_count.
    - At count==T_HIGH-1: go to the matching LOW state if bit_count<8, else to ACK_LOW with bit_count=0.
  - AACK_LOW / DACK_LOW
    - scl_o=0.
    - At DRV_PT: sda_o=1 for address ACK and write ACK.
    - In read, drive sda_o=0 (ACK) when byte_count<len, else 1 (NACK).
  - AACK_HIGH / DACK_HIGH
    - At SMP_PT in address/write phases: sda_i==1 sets nack_err and flags an abort.
    - At T_HIGH-1: go to STOP_LOW on abort, or when byte_count==len.
    - Otherwise go to DATA_LOW.
  - STOP_LOW: scl_o=0; sda_o=0 at DRV_PT.
  - STOP_HIGH
    - scl_o=1; sda_o=1 at SMP_PT.
    - At T_HIGH-1: go to IDLE and pulse done.
- Write bytes:
  - wr_req pulses at AACK_HIGH/DACK_HIGH count==T_HIGH-1 when another byte follows.
  - wr_data is loaded into the shift register in that same cycle.
- Read bytes:
  - rd_valid pulses at DATA_HIGH count==T_HIGH-1 of bit 8.
  - rd_data updates in the same cycle; byte_count increments.
- Write byte_count increments on each DACK.
- cmd_len==0 is an address probe: ADDR, ACK, STOP.
- cmd_valid while busy is ignored. No queueing.

Optional Feature:
- Macro: I2C_CLK_STRETCH_EN.
- Defined:
  - In every HIGH-phase state and START_HIGH-equivalent states, the phase counter holds while scl_i==0 (target stretching).
  - SMP_PT sampling is also deferred until scl_i==1.
- Undefined: scl_i is ignored; timing is purely count-based.

Test Plan:
- Write, addr=0x50, len=2, data 0xA5,0x3C, target ACKs all:
  - SDA bit stream 1010000_0, A, A5, A, 3C, A, STOP.
  - 2 wr_req pulses, done once, nack_err=0.
- Read, addr=0x21, len=3, target returns 0x11,0x22,0x33:
  - 3 rd_valid pulses with those values.
  - Controller drives ACK, ACK, NACK, then STOP.
- Address NACK, addr=0x7F, sda_i held 1:
  - nack_err=1 after AACK_HIGH.
  - STOP, done, no wr_req/rd_valid.
  - nack_err clears on the next accept.
- cmd_len=7 with MAX_BYTES=4 → exactly 4 data bytes, then STOP. cmd_len=0 → address-only probe then STOP.
- rst asserted during DATA_LOW of byte 1 → next cycle scl_o=1, sda_o=1, busy=0, cmd_ready=1, no done pulse.
- With I2C_CLK_STRETCH_EN, scl_i held 0 for 100 cycles in ADDR_HIGH → high phase lasts T_HIGH+100 cycles. Without the macro → T_HIGH cycles.

Source files
------------

// File: rtl/i2c_master_engine.sv
// Parametrised I2C master engine: timed START/bit/ACK/STOP phases, multi-byte read/write, open-drain drive.
// Optional target clock stretching is enabled by defining I2C_CLK_STRETCH_EN.
module i2c_master_engine #(
    parameter int T_HD      = 225,
    parameter int T_LOW     = 250,
    parameter int T_HIGH    = 225,
    parameter int DRV_PT    = 150,
    parameter int SMP_PT    = 50,
    parameter int CNT_W     = 10,
    parameter int MAX_BYTES = 4,
    parameter int LEN_W     = $clog2(MAX_BYTES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [6:0]       cmd_addr,
    input  logic             cmd_rw,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [7:0]       wr_data,
    output logic             wr_req,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    output logic             done,
    output logic             nack_err,
    output logic             busy,
    output logic             scl_o,
    output logic             sda_o,
    input  logic             sda_i,
    input  logic             scl_i
);

    typedef enum logic [3:0] {
        IDLE, START, ADDR_LOW, ADDR_HIGH, AACK_LOW, AACK_HIGH,
        DATA_LOW, DATA_HIGH, DACK_LOW, DACK_HIGH, STOP_LOW, STOP_HIGH
    } state_t;

    localparam logic [CNT_W-1:0] C_HD_M1   = CNT_W'(T_HD - 1);
    localparam logic [CNT_W-1:0] C_LOW_M1  = CNT_W'(T_LOW - 1);
    localparam logic [CNT_W-1:0] C_HIGH_M1 = CNT_W'(T_HIGH - 1);
    localparam logic [CNT_W-1:0] C_DRV     = CNT_W'(DRV_PT);
    localparam logic [CNT_W-1:0] C_SMP     = CNT_W'(SMP_PT);
    localparam logic [LEN_W-1:0] C_MAXLEN  = LEN_W'(MAX_BYTES);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_q, bit_d;
    logic [LEN_W-1:0] byte_q, byte_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       rd_data_q, rd_data_d;
    logic             rw_q, rw_d;
    logic             abort_q, abort_d;
    logic             scl_q, scl_d;
    logic             sda_q, sda_d;
    logic             nack_q, nack_d;
    logic             wr_req_q, wr_req_d;
    logic             rd_valid_q, rd_valid_d;
    logic             done_q, done_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             hold_s;

`ifndef I2C_CLK_STRETCH_EN
    logic unused_scl_s;
    assign unused_scl_s = scl_i;
`endif

    // Next-state, phase counter and line-drive decisions
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        byte_d     = byte_q;
        len_d      = len_q;
        rd_data_d  = rd_data_q;
        rw_d       = rw_q;
        abort_d    = abort_q;
        sda_d      = sda_q;
        nack_d     = nack_q;
        wr_req_d   = 1'b0;
        rd_valid_d = 1'b0;
        done_d     = 1'b0;
`ifdef I2C_CLK_STRETCH_EN
        // A target holding SCL low freezes every phase in which we release SCL
        hold_s = !scl_i && (state_q == START || state_q == ADDR_HIGH || state_q == AACK_HIGH ||
                            state_q == DATA_HIGH || state_q == DACK_HIGH || state_q == STOP_HIGH);
`else
        hold_s = 1'b0;
`endif
        if (wr_req_q) begin
            shift_d = wr_data;
        end else begin
            shift_d = shift_q;
        end

        if (hold_s) begin
            cnt_d = cnt_q;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        state_d = START;
                        rw_d    = cmd_rw;
                        len_d   = (cmd_len > C_MAXLEN) ? C_MAXLEN : cmd_len;
                        shift_d = {cmd_addr, cmd_rw};
                        nack_d  = 1'b0;
                        abort_d = 1'b0;
                        bit_d   = 4'd0;
                        byte_d  = {LEN_W{1'b0}};
                        sda_d   = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
                START: begin
                    state_d = (cnt_q >= C_HD_M1) ? ADDR_LOW : START;
                end
                ADDR_LOW, DATA_LOW: begin
                    if (cnt_q == C_DRV) begin
                        sda_d = (state_q == DATA_LOW && rw_q) ? 1'b1 : shift_q[7];
                    end else begin
                        sda_d = sda_q;
                    end
                    if (cnt_q == C_LOW_M1) begin
                        state_d = (state_q == ADDR_LOW) ? ADDR_HIGH : DATA_HIGH;
                    end else begin
                        state_d = state_q;
                    end
                end
                ADDR_HIGH, DATA_HIGH: begin
                    if (cnt_q == C_SMP) begin
                        shift_d = {shift_q[6:0], sda_i};
                        bit_d   = bit_q + 4'd1;
                    end else begin
                        bit_d   = bit_q;
                    end
                    if (cnt_q == C_HIGH_M1) begin
                        if (bit_q < 4'd8) begin
                            state_d = (state_q == ADDR_HIGH) ? ADDR_LOW : DATA_LOW;
                        end else begin
                            state_d = (state_q == ADDR_HIGH) ? AACK_LOW : DACK_LOW;
                            bit_d   = 4'd0;
                            if (state_q == DATA_HIGH) begin
                                byte_d     = byte_q + LEN_W'(1);
                                rd_valid_d = rw_q;
                                rd_data_d  = rw_q ? shift_q : rd_data_q;
                            end else begin
                                byte_d = byte_q;
                            end
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                AACK_LOW, DACK_LOW: begin
                    // In read data we generate ACK for every byte except the last one
                    if (cnt_q == C_DRV) begin
                        sda_d = (state_q == DACK_LOW && rw_q) ? (byte_q >= len_q) : 1'b1;
                    end else begin
                        sda_d = sda_q;
                    end
                    if (cnt_q == C_LOW_M1) begin
                        state_d = (state_q == AACK_LOW) ? AACK_HIGH : DACK_HIGH;
                    end else begin
                        state_d = state_q;
                    end
                end
                AACK_HIGH, DACK_HIGH: begin
                    if (cnt_q == C_SMP && (state_q == AACK_HIGH || !rw_q) && sda_i) begin
                        nack_d  = 1'b1;
                        abort_d = 1'b1;
                    end else begin
                        nack_d  = nack_q;
                    end
                    if (cnt_q == C_HIGH_M1) begin
                        if (abort_q || byte_q == len_q) begin
                            state_d = STOP_LOW;
                        end else begin
                            state_d  = DATA_LOW;
                            wr_req_d = !rw_q;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                STOP_LOW: begin
                    sda_d   = (cnt_q == C_DRV) ? 1'b0 : sda_q;
                    state_d = (cnt_q == C_LOW_M1) ? STOP_HIGH : STOP_LOW;
                end
                STOP_HIGH: begin
                    sda_d = (cnt_q == C_SMP) ? 1'b1 : sda_q;
                    if (cnt_q == C_HIGH_M1) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = STOP_HIGH;
                    end
                end
                default: begin
                    state_d = IDLE;
                    sda_d   = 1'b1;
                end
            endcase

            if (state_d != state_q || state_q == IDLE) begin
                cnt_d = {CNT_W{1'b0}};
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        case (state_d)
            ADDR_LOW, AACK_LOW, DATA_LOW, DACK_LOW, STOP_LOW: scl_d = 1'b0;
            default:                                          scl_d = 1'b1;
        endcase
        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    // State and output registers; reset releases both lines without a STOP
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= {CNT_W{1'b0}};
            bit_q      <= 4'd0;
            byte_q     <= {LEN_W{1'b0}};
            len_q      <= {LEN_W{1'b0}};
            shift_q    <= 8'h00;
            rd_data_q  <= 8'h00;
            rw_q       <= 1'b0;
            abort_q    <= 1'b0;
            scl_q      <= 1'b1;
            sda_q      <= 1'b1;
            nack_q     <= 1'b0;
            wr_req_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            byte_q     <= byte_d;
            len_q      <= len_d;
            shift_q    <= shift_d;
            rd_data_q  <= rd_data_d;
            rw_q       <= rw_d;
            abort_q    <= abort_d;
            scl_q      <= scl_d;
            sda_q      <= sda_d;
            nack_q     <= nack_d;
            wr_req_q   <= wr_req_d;
            rd_valid_q <= rd_valid_d;
            done_q     <= done_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
        end
    end

    assign cmd_ready = ready_q;
    assign busy      = busy_q;
    assign scl_o     = scl_q;
    assign sda_o     = sda_q;
    assign wr_req    = wr_req_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign done      = done_q;
    assign nack_err  = nack_q;

endmodule

// File: tb/tb_i2c_master_engine.sv
// Scoreboard bench for i2c_master_engine with a behavioural I2C target on a wired-AND SDA line.
module tb_i2c_master_engine;
    localparam int T_HD = 12, T_LOW = 10, T_HIGH = 9, DRV_PT = 4, SMP_PT = 3, CNT_W = 5;
    localparam int MAX_BYTES = 4;
    localparam int LEN_W = $clog2(MAX_BYTES + 1);
    localparam int BUDGET = 4000;
`ifdef I2C_CLK_STRETCH_EN
    localparam int EXP_HIGH = T_HIGH + 100;
`else
    localparam int EXP_HIGH = T_HIGH;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cmd_valid = 1'b0;
    logic [6:0] cmd_addr = 7'h00;
    logic cmd_rw = 1'b0;
    logic [LEN_W-1:0] cmd_len = '0;
    logic [7:0] wr_data = 8'h00;
    logic cmd_ready, wr_req, rd_valid, done, nack_err, busy, scl_o, sda_o, sda_i, scl_i;
    logic [7:0] rd_data;

    logic tgt_drv = 1'b1;
    logic tgt_nack = 1'b0;
    logic scl_hold = 1'b0;
    logic [7:0] tgt_rd [0:7];
    logic [7:0] wr_tab [0:7];
    int wr_base = 0;

    assign sda_i = sda_o & tgt_drv;
    assign scl_i = scl_o & ~scl_hold;

    i2c_master_engine #(.T_HD(T_HD), .T_LOW(T_LOW), .T_HIGH(T_HIGH), .DRV_PT(DRV_PT),
                        .SMP_PT(SMP_PT), .CNT_W(CNT_W), .MAX_BYTES(MAX_BYTES), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_rw(cmd_rw), .cmd_len(cmd_len), .wr_data(wr_data), .wr_req(wr_req), .rd_data(rd_data),
        .rd_valid(rd_valid), .done(done), .nack_err(nack_err), .busy(busy), .scl_o(scl_o),
        .sda_o(sda_o), .sda_i(sda_i), .scl_i(scl_i));

    always #5 clk = ~clk;

    int n_wr = 0, n_done = 0, n_start = 0, n_stop = 0;
    logic [7:0] obs_bus [$];
    logic [7:0] obs_rd [$];
    logic obs_ack [$];

    // Write-byte supplier and DUT pulse recorder
    always @(negedge clk) begin
        if (wr_req) begin
            wr_data = wr_tab[(n_wr - wr_base) & 7];
            n_wr++;
        end
        if (done) n_done++;
        if (rd_valid) obs_rd.push_back(rd_data);
    end

    logic prev_scl = 1'b1, prev_sda = 1'b1, line, in_frame = 1'b0, t_rw = 1'b0, rd_on = 1'b0;
    int bitn = 0, frame = 0, rd_idx = 0;
    logic [7:0] rx = 8'h00, rd_byte = 8'h00;

    // Target model: decodes START/STOP/bits, ACKs or NACKs, returns read data
    always @(negedge clk) begin
        line = sda_o & tgt_drv;
        if (scl_o && prev_scl && prev_sda && !line) begin
            n_start++; in_frame = 1'b1; bitn = -1; frame = 0; rd_idx = 0; rd_on = 1'b0; tgt_drv = 1'b1;
        end else if (scl_o && prev_scl && !prev_sda && line) begin
            n_stop++; in_frame = 1'b0;
        end else if (in_frame && scl_o && !prev_scl) begin
            if (bitn < 8) rx = {rx[6:0], line};
            else if (frame > 0 && t_rw) begin obs_ack.push_back(line); rd_on = !line; end
        end else if (in_frame && !scl_o && prev_scl) begin
            if (bitn == 7) begin
                bitn = 8;
                if (frame == 0) begin
                    t_rw = rx[0]; obs_bus.push_back(rx); tgt_drv = tgt_nack; rd_on = rx[0] && !tgt_nack;
                end else if (!t_rw) begin
                    obs_bus.push_back(rx); tgt_drv = tgt_nack;
                end else tgt_drv = 1'b1;
            end else if (bitn == 8) begin
                bitn = 0; frame++;
                if (rd_on) begin rd_byte = tgt_rd[rd_idx & 7]; rd_idx++; tgt_drv = rd_byte[7]; end
                else tgt_drv = 1'b1;
            end else begin
                bitn++;
                tgt_drv = (frame > 0 && rd_on) ? rd_byte[3'(7 - bitn)] : 1'b1;
            end
        end
        prev_scl = scl_o;
        prev_sda = sda_o & tgt_drv;
    end

    int n_cmp = 0, n_bad = 0;
    logic nack_at_accept;

    task automatic issue(input logic [6:0] a, input logic rw, input int len);
        int d0;
        bit ok;
        d0 = n_done; wr_base = n_wr; ok = 1'b0;
        @(negedge clk);
        cmd_addr = a; cmd_rw = rw; cmd_len = LEN_W'(len); cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0; nack_at_accept = nack_err;
        for (int i = 0; i < BUDGET; i++) begin
            if (n_done != d0) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL done_timeout: actual done=0 required done=1"); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({cmd_ready, busy, scl_o, sda_o, wr_req, rd_valid, done, nack_err, rd_data} !== {8'b10110000, 8'h00}) begin
            n_bad++;
            $display("FAIL reset_outputs: actual=%b required=%b",
                     {cmd_ready, busy, scl_o, sda_o, wr_req, rd_valid, done, nack_err, rd_data}, {8'b10110000, 8'h00});
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);
        n_cmp++;
        if ({cmd_ready, busy, scl_o, sda_o} !== 4'b1011) begin
            n_bad++; $display("FAIL idle_hold: actual=%b required=1011", {cmd_ready, busy, scl_o, sda_o});
        end
    endtask

    task automatic test_write();
        logic [7:0] exp_bus [$];
        logic [7:0] e;
        int p, w0, s0, d0;
        wr_tab[0] = 8'hA5; wr_tab[1] = 8'h3C;
        exp_bus.push_back(8'hA0); exp_bus.push_back(8'hA5); exp_bus.push_back(8'h3C);
        p = obs_bus.size(); w0 = n_wr; s0 = n_stop; d0 = n_done;
        issue(7'h50, 1'b0, 2);
        repeat (3) @(negedge clk);
        while (exp_bus.size() > 0) begin
            e = exp_bus.pop_front(); n_cmp++;
            if (p >= obs_bus.size()) begin n_bad++; $display("FAIL write_bus: actual=none required=%02h", e); end
            else if (obs_bus[p] !== e) begin n_bad++; $display("FAIL write_bus: actual=%02h required=%02h", obs_bus[p], e); end
            p++;
        end
        n_cmp++; if (n_wr - w0 != 2) begin n_bad++; $display("FAIL write_wr_req: actual=%0d required=2", n_wr - w0); end
        n_cmp++; if (n_done - d0 != 1) begin n_bad++; $display("FAIL write_done: actual=%0d required=1", n_done - d0); end
        n_cmp++; if (n_stop - s0 != 1) begin n_bad++; $display("FAIL write_stop: actual=%0d required=1", n_stop - s0); end
        n_cmp++; if (nack_err !== 1'b0) begin n_bad++; $display("FAIL write_nack: actual=%b required=0", nack_err); end
    endtask

    task automatic test_read();
        logic [7:0] exp_rd [$];
        logic exp_ack [$];
        logic [7:0] e;
        logic a;
        int pr, pa, pb, w0;
        tgt_rd[0] = 8'h11; tgt_rd[1] = 8'h22; tgt_rd[2] = 8'h33;
        exp_rd.push_back(8'h11); exp_rd.push_back(8'h22); exp_rd.push_back(8'h33);
        exp_ack.push_back(1'b0); exp_ack.push_back(1'b0); exp_ack.push_back(1'b1);
        pr = obs_rd.size(); pa = obs_ack.size(); pb = obs_bus.size(); w0 = n_wr;
        issue(7'h21, 1'b1, 3);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (obs_bus.size() != pb + 1 || obs_bus[pb] !== 8'h43) begin
            n_bad++; $display("FAIL read_addr: actual count=%0d required 1 byte 43", obs_bus.size() - pb);
        end
        while (exp_rd.size() > 0) begin
            e = exp_rd.pop_front(); n_cmp++;
            if (pr >= obs_rd.size()) begin n_bad++; $display("FAIL read_data: actual=none required=%02h", e); end
            else if (obs_rd[pr] !== e) begin n_bad++; $display("FAIL read_data: actual=%02h required=%02h", obs_rd[pr], e); end
            pr++;
        end
        while (exp_ack.size() > 0) begin
            a = exp_ack.pop_front(); n_cmp++;
            if (pa >= obs_ack.size()) begin n_bad++; $display("FAIL read_ack: actual=none required=%b", a); end
            else if (obs_ack[pa] !== a) begin n_bad++; $display("FAIL read_ack: actual=%b required=%b", obs_ack[pa], a); end
            pa++;
        end
        n_cmp++; if (obs_rd.size() != pr) begin n_bad++; $display("FAIL read_extra: actual=%0d required=%0d", obs_rd.size(), pr); end
        n_cmp++; if (n_wr != w0) begin n_bad++; $display("FAIL read_wr_req: actual=%0d required=0", n_wr - w0); end
    endtask

    task automatic test_addr_nack();
        int w0, r0, s0, pb;
        tgt_nack = 1'b1;
        w0 = n_wr; r0 = obs_rd.size(); s0 = n_stop; pb = obs_bus.size();
        issue(7'h7F, 1'b0, 1);
        repeat (3) @(negedge clk);
        n_cmp++; if (nack_err !== 1'b1) begin n_bad++; $display("FAIL nack_set: actual=%b required=1", nack_err); end
        n_cmp++;
        if (n_wr != w0 || obs_rd.size() != r0) begin
            n_bad++; $display("FAIL nack_no_data: actual wr=%0d rd=%0d required 0 0", n_wr - w0, obs_rd.size() - r0);
        end
        n_cmp++; if (n_stop - s0 != 1) begin n_bad++; $display("FAIL nack_stop: actual=%0d required=1", n_stop - s0); end
        n_cmp++;
        if (obs_bus.size() != pb + 1 || obs_bus[pb] !== 8'hFE) begin
            n_bad++; $display("FAIL nack_addr: actual count=%0d required 1 byte FE", obs_bus.size() - pb);
        end
        tgt_nack = 1'b0;
        issue(7'h50, 1'b0, 0);
        n_cmp++; if (nack_at_accept !== 1'b0) begin n_bad++; $display("FAIL nack_clear: actual=%b required=0", nack_at_accept); end
    endtask

    task automatic test_len_limits();
        logic [7:0] exp_bus [$];
        logic [7:0] e;
        int p, w0;
        for (int i = 0; i < 8; i++) wr_tab[i] = 8'(8'h80 + i * 8'h11);
        exp_bus.push_back(8'h24);
        for (int i = 0; i < MAX_BYTES; i++) exp_bus.push_back(8'(8'h80 + i * 8'h11));
        exp_bus.push_back(8'h66);
        p = obs_bus.size(); w0 = n_wr;
        issue(7'h12, 1'b0, 7);
        n_cmp++; if (n_wr - w0 != MAX_BYTES) begin n_bad++; $display("FAIL max_wr_req: actual=%0d required=%0d", n_wr - w0, MAX_BYTES); end
        w0 = n_wr;
        issue(7'h33, 1'b0, 0);
        repeat (3) @(negedge clk);
        n_cmp++; if (n_wr != w0) begin n_bad++; $display("FAIL probe_wr_req: actual=%0d required=0", n_wr - w0); end
        while (exp_bus.size() > 0) begin
            e = exp_bus.pop_front(); n_cmp++;
            if (p >= obs_bus.size()) begin n_bad++; $display("FAIL len_bus: actual=none required=%02h", e); end
            else if (obs_bus[p] !== e) begin n_bad++; $display("FAIL len_bus: actual=%02h required=%02h", obs_bus[p], e); end
            p++;
        end
        n_cmp++; if (obs_bus.size() != p) begin n_bad++; $display("FAIL len_extra: actual=%0d required=%0d", obs_bus.size(), p); end
    endtask

    task automatic test_reset_mid();
        int w0, d0, k;
        wr_tab[0] = 8'hC3; wr_tab[1] = 8'h5A;
        w0 = n_wr; wr_base = n_wr; k = 0;
        @(negedge clk);
        cmd_addr = 7'h50; cmd_rw = 1'b0; cmd_len = LEN_W'(2); cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        while (n_wr == w0 && k < BUDGET) begin @(negedge clk); k++; end
        n_cmp++; if (n_wr == w0) begin n_bad++; $display("FAIL rstmid_timeout: actual wr_req=0 required=1"); end
        repeat (3) @(negedge clk);
        d0 = n_done;
        rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if ({scl_o, sda_o, busy, cmd_ready} !== 4'b1101) begin
            n_bad++; $display("FAIL rstmid_lines: actual=%b required=1101", {scl_o, sda_o, busy, cmd_ready});
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        n_cmp++; if (n_done != d0) begin n_bad++; $display("FAIL rstmid_done: actual=%0d required=0", n_done - d0); end
    endtask

    task automatic test_stretch();
        int k, n, d0;
        d0 = n_done; k = 0; n = 0;
        @(negedge clk);
        cmd_addr = 7'h50; cmd_rw = 1'b0; cmd_len = LEN_W'(0); cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        while (scl_o && k < BUDGET) begin @(negedge clk); k++; end
        while (!scl_o && k < BUDGET) begin @(negedge clk); k++; end
        while (scl_o && k < BUDGET) begin
            n++;
            if (n == 1) scl_hold = 1'b1;
            if (n == 101) scl_hold = 1'b0;
            @(negedge clk); k++;
        end
        scl_hold = 1'b0;
        n_cmp++; if (n != EXP_HIGH) begin n_bad++; $display("FAIL stretch_high: actual=%0d required=%0d", n, EXP_HIGH); end
        k = 0;
        while (n_done == d0 && k < BUDGET) begin @(negedge clk); k++; end
        n_cmp++; if (n_done == d0) begin n_bad++; $display("FAIL stretch_done: actual=0 required=1"); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_addr_nack();
        test_len_limits();
        test_reset_mid();
        test_stretch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
